kbd_cmd_ctrl: RTL and testbench

KBD_CMD_CTRL -- requirements
Module: kbd_cmd_ctrl

---
 rtl/kbd_cmd_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_kbd_cmd_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_cmd_ctrl: PS/2 keyboard command sequencer (reset 0xFF, LEDs 0xED+arg) |
// | with ACK/resend/timeout retry. Option macro: KBD_AUTO_INIT_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module kbd_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] fwd_data,
  output logic       fwd_valid,
  output logic       ready,
  output logic       error,
  output logic [2:0] led_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0]    C_CMD_RESET = 8'hFF;
  localparam logic [7:0]    C_CMD_LED   = 8'hED;
  localparam logic [7:0]    C_ACK       = 8'hFA;
  localparam logic [7:0]    C_RESEND    = 8'hFE;
  localparam logic [7:0]    C_BAT_OK    = 8'hAA;
  localparam logic [7:0]    C_BAT_FAIL  = 8'hFC;
  localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] C_RETRY_MAX = RW'(MAX_RETRY);

`ifdef KBD_AUTO_INIT_EN
  localparam logic C_READY_RST = 1'b0;
  localparam logic C_BOOT_RST  = 1'b1;
`else
  localparam logic C_READY_RST = 1'b1;
  localparam logic C_BOOT_RST  = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_SEND_CMD     = 4'd1,
    ST_WAIT_CMD_TX  = 4'd2,
    ST_WAIT_CMD_ACK = 4'd3,
    ST_SEND_ARG     = 4'd4,
    ST_WAIT_ARG_TX  = 4'd5,
    ST_WAIT_ARG_ACK = 4'd6,
    ST_WAIT_BAT     = 4'd7
  } state_t;

  state_t          state_q, state_d;
  logic            pend_init_q, pend_init_d;
  logic            pend_led_q, pend_led_d;
  logic [2:0]      pend_mask_q, pend_mask_d;
  logic            op_init_q, op_init_d;
  logic [2:0]      op_mask_q, op_mask_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      fwd_data_q, fwd_data_d;
  logic            fwd_valid_q, fwd_valid_d;
  logic            error_q, error_d;
  logic [2:0]      led_state_q, led_state_d;
  logic            ready_q, ready_d;
  logic            boot_q, boot_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            w_tx_valid;
  logic            w_in_wait;
  logic            w_special;
  logic            w_timeout;
  logic            w_retry;
  logic            w_ack;
  logic            w_resend;

  always_comb begin
    state_d     = state_q;
    pend_init_d = pend_init_q | init_req | boot_q;
    pend_led_d  = pend_led_q | led_req;
    pend_mask_d = led_req ? led_mask : pend_mask_q;
    op_init_d   = op_init_q;
    op_mask_d   = op_mask_q;
    tx_data_d   = tx_data_q;
    fwd_data_d  = fwd_data_q;
    fwd_valid_d = 1'b0;
    error_d     = error_q;
    led_state_d = led_state_q;
    boot_d      = 1'b0;
    retry_d     = retry_q;
    w_tx_valid  = 1'b0;
    w_retry     = 1'b0;

    w_in_wait = (state_q inside {ST_WAIT_CMD_TX, ST_WAIT_CMD_ACK, ST_WAIT_ARG_TX,
                                 ST_WAIT_ARG_ACK, ST_WAIT_BAT});
    w_special = (rx_data inside {C_ACK, C_RESEND, C_BAT_OK, C_BAT_FAIL});
    w_ack     = rx_valid && (rx_data == C_ACK);
    w_resend  = rx_valid && (rx_data == C_RESEND);
    // A byte arriving on the timeout cycle wins; the counter saturates so the
    // timeout simply fires on the next quiet cycle.
    w_timeout = w_in_wait && !rx_valid && (tmo_q >= C_TMO_LAST);
    tmo_d     = !w_in_wait ? '0 : (tmo_q >= C_TMO_LAST) ? tmo_q : tmo_q + TW'(1);

    if (rx_valid && !(w_in_wait && w_special)) begin
      fwd_valid_d = 1'b1;
      fwd_data_d  = rx_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_init_q || init_req) begin
          state_d     = ST_SEND_CMD;
          tx_data_d   = C_CMD_RESET;
          op_init_d   = 1'b1;
          pend_init_d = 1'b0;
          error_d     = 1'b0;
          retry_d     = '0;
        end else if (pend_led_q || led_req) begin
          state_d     = ST_SEND_CMD;
          tx_data_d   = C_CMD_LED;
          op_init_d   = 1'b0;
          op_mask_d   = pend_mask_d;
          pend_led_d  = 1'b0;
          error_d     = 1'b0;
          retry_d     = '0;
        end
      end
      ST_SEND_CMD: begin
        if (!tx_busy) begin
          w_tx_valid = 1'b1;
          state_d    = ST_WAIT_CMD_TX;
        end
      end
      ST_SEND_ARG: begin
        if (!tx_busy) begin
          w_tx_valid = 1'b1;
          state_d    = ST_WAIT_ARG_TX;
        end
      end
      ST_WAIT_CMD_TX: begin
        if (tx_done)        state_d = ST_WAIT_CMD_ACK;
        else if (w_timeout) w_retry = 1'b1;
      end
      ST_WAIT_ARG_TX: begin
        if (tx_done)        state_d = ST_WAIT_ARG_ACK;
        else if (w_timeout) w_retry = 1'b1;
      end
      ST_WAIT_CMD_ACK: begin
        if (w_ack) begin
          if (op_init_q) begin
            state_d = ST_WAIT_BAT;
          end else begin
            state_d   = ST_SEND_ARG;
            tx_data_d = {5'b0, op_mask_q};
            retry_d   = '0;
          end
        end else if (w_resend || w_timeout) begin
          w_retry = 1'b1;
        end
      end
      ST_WAIT_ARG_ACK: begin
        if (w_ack) begin
          led_state_d = op_mask_q;
          state_d     = ST_IDLE;
        end else if (w_resend || w_timeout) begin
          w_retry = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (rx_valid && rx_data == C_BAT_OK) begin
          state_d = ST_IDLE;
        end else if (rx_valid && rx_data == C_BAT_FAIL) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (w_timeout) begin
          w_retry = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A failed BAT wait restarts the whole reset command.
    if (w_retry) begin
      if (retry_q == C_RETRY_MAX) begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        retry_d = retry_q + RW'(1);
        if (state_q == ST_WAIT_ARG_TX || state_q == ST_WAIT_ARG_ACK) begin
          state_d = ST_SEND_ARG;
        end else begin
          state_d = ST_SEND_CMD;
          if (state_q == ST_WAIT_BAT) tx_data_d = C_CMD_RESET;
        end
      end
    end

    if (state_d != state_q) tmo_d = '0;

    ready_d = (state_d == ST_IDLE) && !pend_init_d && !pend_led_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_init_q <= 1'b0;
      pend_led_q  <= 1'b0;
      pend_mask_q <= 3'b000;
      op_init_q   <= 1'b0;
      op_mask_q   <= 3'b000;
      tx_data_q   <= 8'h00;
      fwd_data_q  <= 8'h00;
      fwd_valid_q <= 1'b0;
      error_q     <= 1'b0;
      led_state_q <= 3'b000;
      ready_q     <= C_READY_RST;
      boot_q      <= C_BOOT_RST;
      retry_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_init_q <= pend_init_d;
      pend_led_q  <= pend_led_d;
      pend_mask_q <= pend_mask_d;
      op_init_q   <= op_init_d;
      op_mask_q   <= op_mask_d;
      tx_data_q   <= tx_data_d;
      fwd_data_q  <= fwd_data_d;
      fwd_valid_q <= fwd_valid_d;
      error_q     <= error_d;
      led_state_q <= led_state_d;
      ready_q     <= ready_d;
      boot_q      <= boot_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = w_tx_valid;
  assign fwd_data  = fwd_data_q;
  assign fwd_valid = fwd_valid_q;
  assign ready     = ready_q;
  assign error     = error_q;
  assign led_state = led_state_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_kbd_cmd_ctrl: scoreboard bench for kbd_cmd_ctrl with a keyboard model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_kbd_cmd_ctrl;
  localparam int TMO  = 100;
  localparam int MAXR = 3;
`ifdef KBD_AUTO_INIT_EN
  localparam int EXP_READY_RST = 0;
`else
  localparam int EXP_READY_RST = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_req = 1'b0, led_req = 1'b0;
  logic [2:0] led_mask = 3'b000;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       busy_force = 1'b0, busy_rand = 1'b0, rand_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] fwd_data;
  logic       fwd_valid;
  logic       ready, error;
  logic [2:0] led_state;

  assign tx_busy = busy_force | busy_rand;

  kbd_cmd_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .led_req(led_req),
    .led_mask(led_mask), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data),
    .rx_valid(rx_valid), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .ready(ready), .error(error), .led_state(led_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    busy_rand = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  typedef struct { logic [7:0] d; int c; } fwd_t;
  logic [7:0] exp_tx_q[$];
  fwd_t       exp_fwd_q[$];
  logic       exp_err = 1'b0;
  logic [2:0] exp_led = 3'b000;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event, required one within the cycle bound", name);
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (tx_valid) begin
        check("tx_valid_while_busy", 32'(tx_busy), 0);
        if (exp_tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx: got %0h, required no transmission", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
        end
      end
      if (fwd_valid) begin
        if (exp_fwd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fwd: got %0h, required no forward", fwd_data);
        end else begin
          fwd_t e;
          e = exp_fwd_q.pop_front();
          check("fwd_byte", 32'(fwd_data), 32'(e.d));
          check("fwd_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  // Reference: a byte is sent once plus once per failure, capped by the retry limit.
  function automatic int attempts(input int nfail);
    return (nfail > MAXR) ? MAXR + 1 : nfail + 1;
  endfunction

  function automatic logic [7:0] rand_plain();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'hFA || b == 8'hFE || b == 8'hAA || b == 8'hFC);
    return b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_fwd(input logic [7:0] b);
    fwd_t e;
    e.d = b; e.c = cyc + 1;
    exp_fwd_q.push_back(e);
    pulse_rx(b);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
  endtask

  task automatic wait_tx();
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    if (!seen) fail_bound("wait_tx");
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) fail_bound(name);
    @(posedge clk); #1;
  endtask

  // Keyboard side of one byte: mode 0 random failure kind, 1 resend, 2 silence.
  task automatic serve_byte(input int nfail, input int mode, input int inject);
    int n;
    n = attempts(nfail);
    for (int a = 0; a < n; a++) begin
      wait_tx();
      idle($urandom_range(0, 3));
      pulse_done();
      idle($urandom_range(0, 3));
      if (inject == 1 || (inject == 2 && $urandom_range(0, 3) == 0)) begin
        send_fwd(inject == 1 ? 8'h1C : rand_plain());
        idle($urandom_range(0, 2));
      end
      if (a < nfail) begin
        if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 0)) pulse_rx(8'hFE);
      end else begin
        pulse_rx(8'hFA);
      end
    end
  endtask

  task automatic run_led(input logic [2:0] m, input int nc, input int na,
                         input int mode, input int inj);
    for (int i = 0; i < attempts(nc); i++) exp_tx_q.push_back(8'hED);
    if (nc <= MAXR)
      for (int i = 0; i < attempts(na); i++) exp_tx_q.push_back({5'b0, m});
    if (nc > MAXR || na > MAXR) exp_err = 1'b1;
    else begin exp_err = 1'b0; exp_led = m; end
    led_mask = m; led_req = 1'b1;
    @(posedge clk); #1 led_req = 1'b0;
    led_mask = 3'($urandom_range(0, 7));
    check("error_clear_on_accept", 32'(error), 0);
    check("ready_low_when_busy", 32'(ready), 0);
    serve_byte(nc, mode, inj);
    if (nc <= MAXR) serve_byte(na, mode, inj);
    wait_ready("led_done");
    check("led_error", 32'(error), 32'(exp_err));
    check("led_state", 32'(led_state), 32'(exp_led));
  endtask

  task automatic run_init(input int nc, input int mode, input bit bat_ok);
    for (int i = 0; i < attempts(nc); i++) exp_tx_q.push_back(8'hFF);
    exp_err = (nc > MAXR) ? 1'b1 : !bat_ok;
    init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    check("init_error_clear", 32'(error), 0);
    serve_byte(nc, mode, 0);
    if (nc <= MAXR) begin
      idle($urandom_range(1, 4));
      pulse_rx(bat_ok ? 8'hAA : 8'hFC);
    end
    wait_ready("init_done");
    check("init_error", 32'(error), 32'(exp_err));
    check("init_led_kept", 32'(led_state), 32'(exp_led));
  endtask

  initial begin
    idle(3);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_fwd_valid", 32'(fwd_valid), 0);
    check("rst_fwd_data", 32'(fwd_data), 0);
    check("rst_error", 32'(error), 0);
    check("rst_led_state", 32'(led_state), 0);
    check("rst_ready", 32'(ready), 32'(EXP_READY_RST));
    reset = 1'b1;
`ifdef KBD_AUTO_INIT_EN
    exp_tx_q.push_back(8'hFF);
    serve_byte(0, 1, 0);
    idle(2);
    pulse_rx(8'hAA);
    wait_ready("auto_init");
    check("auto_init_error", 32'(error), 0);
`else
    idle(2);
    check("ready_after_release", 32'(ready), 1);
`endif

    run_led(3'b101, 0, 0, 1, 0);
    run_led(3'b101, 2, 0, 1, 0);
    run_led(3'b010, 4, 0, 2, 0);
    run_led(3'b011, 0, 0, 1, 1);
    run_init(0, 1, 1'b1);
    run_init(1, 0, 1'b0);
    run_init(5, 1, 1'b1);
    run_led(3'b110, 0, 4, 1, 0);

    rand_busy = 1'b1;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 2) != 0)
        run_led(3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 4), 0, 2);
      else
        run_init($urandom_range(0, 4), 0, $urandom_range(0, 1) == 1);
    end
    rand_busy = 1'b0;
    idle(2);

    // Simultaneous requests held off by a busy transmitter.
    exp_tx_q.push_back(8'hFF);
    exp_tx_q.push_back(8'hED);
    exp_tx_q.push_back(8'h03);
    busy_force = 1'b1;
    led_mask = 3'b011; init_req = 1'b1; led_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0; led_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_tx_while_busy", 32'(tx_valid), 0);
    end
    @(posedge clk); #1 busy_force = 1'b0;
    serve_byte(0, 1, 0);
    idle(2);
    pulse_rx(8'hAA);
    check("ready_led_pending", 32'(ready), 0);
    serve_byte(0, 1, 0);
    serve_byte(0, 1, 0);
    wait_ready("dual_req");
    check("dual_error", 32'(error), 0);
    check("dual_led_state", 32'(led_state), 3);

    // Init arriving mid-LED waits for the LED sequence to finish.
    exp_tx_q.push_back(8'hED);
    exp_tx_q.push_back(8'h04);
    exp_tx_q.push_back(8'hFF);
    led_mask = 3'b100; led_req = 1'b1;
    @(posedge clk); #1 led_req = 1'b0;
    wait_tx();
    pulse_done();
    init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    pulse_rx(8'hFA);
    serve_byte(0, 1, 0);
    check("ready_init_deferred", 32'(ready), 0);
    check("deferred_led_state", 32'(led_state), 4);
    serve_byte(0, 1, 0);
    idle(2);
    pulse_rx(8'hAA);
    wait_ready("deferred_init");
    check("deferred_error", 32'(error), 0);

    // Reset while tx_valid is being presented.
    led_mask = 3'b110; led_req = 1'b1;
    @(posedge clk); #1 led_req = 1'b0;
    check("tx_valid_pre_reset", 32'(tx_valid), 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_led_state", 32'(led_state), 0);
    check("mid_rst_error", 32'(error), 0);
    check("mid_rst_ready", 32'(ready), 32'(EXP_READY_RST));
    idle(3);
    reset = 1'b1;
    exp_led = 3'b000;
`ifdef KBD_AUTO_INIT_EN
    exp_tx_q.push_back(8'hFF);
    serve_byte(0, 1, 0);
    idle(2);
    pulse_rx(8'hAA);
    wait_ready("auto_init_again");
`else
    idle(30);
`endif
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_led_state", 32'(led_state), 0);

    idle(5);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 0);
    check("fwd_queue_drained", 32'(exp_fwd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
